// File: rtl/com_sched.sv
// Round-robin scheduler sharing one com_cs link controller between NREQ requesters,
// plus an independent single-entry receive buffer. Optional counters: COM_SCHED_STAT_EN.
module com_sched #(
  parameter int NREQ      = 4,
  parameter int RETRY_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_send,
  input  logic [4*NREQ-1:0] req_btype,
  input  logic [12*NREQ-1:0] req_dlen,
  input  logic [12*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   req_done,
  output logic [NREQ-1:0]   req_fail,
  output logic              fs_send,
  input  logic              fd_send,
  input  logic              fd_txer,
  output logic [3:0]        send_btype,
  output logic [11:0]       send_dlen,
  output logic [11:0]       ram_addr_init,
  input  logic              fs_read,
  input  logic [3:0]        read_btype,
  output logic              fd_read,
  output logic              rcv_valid,
  output logic [3:0]        rcv_btype,
  input  logic              rcv_ready,
  output logic              busy
`ifdef COM_SCHED_STAT_EN
  ,
  output logic [15:0]       stat_ok,
  output logic [15:0]       stat_fail,
  output logic [15:0]       stat_drop
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_SEND,
    S_DRAIN,
    S_RETRY,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [NREQ-1:0] grant_q;
  logic [RW-1:0]   retry_cnt_q;
  logic            txer_q;
  logic [3:0]      send_btype_q;
  logic [11:0]     send_dlen_q;
  logic [11:0]     ram_addr_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;

  // First set request at or after ptr_q, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr_q) + k) % NREQ;
      if (!win_found && req_send[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req_send) state_d = S_ARB;
      S_ARB:   state_d = win_found ? S_SEND : S_IDLE;
      S_SEND:  if (fd_send) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!fd_send) begin
          if (txer_q && (retry_cnt_q < RW'(RETRY_MAX))) state_d = S_RETRY;
          else                                          state_d = S_DONE;
        end
      end
      S_RETRY: state_d = S_SEND;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      retry_cnt_q  <= '0;
      txer_q       <= 1'b0;
      send_btype_q <= '0;
      send_dlen_q  <= '0;
      ram_addr_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_ARB: begin
          if (win_found) begin
            owner_q      <= win_idx;
            grant_q      <= NREQ'(1) << win_idx;
            send_btype_q <= req_btype[4*win_idx +: 4];
            send_dlen_q  <= req_dlen[12*win_idx +: 12];
            ram_addr_q   <= req_addr[12*win_idx +: 12];
            retry_cnt_q  <= '0;
            txer_q       <= 1'b0;
          end
        end
        S_SEND:  if (fd_send) txer_q <= fd_txer;
        S_RETRY: retry_cnt_q <= retry_cnt_q + 1'b1;
        S_DONE: begin
          grant_q <= '0;
          ptr_q   <= (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant         = grant_q;
  assign fs_send       = (state_q == S_SEND);
  assign req_done      = (state_q == S_DONE) ? grant_q : '0;
  assign req_fail      = (state_q == S_DONE && txer_q) ? grant_q : '0;
  assign send_btype    = send_btype_q;
  assign send_dlen     = send_dlen_q;
  assign ram_addr_init = ram_addr_q;
  assign busy          = (state_q != S_IDLE);

  // Receive path: a buffer being drained this cycle counts as free, so capture wins.
  logic       fs_read_q;
  logic       rcv_valid_q;
  logic [3:0] rcv_btype_q;
  logic       fd_read_q;
  logic       rd_rise;
  logic       rd_take;
  logic       rd_drop;

  assign rd_rise = fs_read && !fs_read_q;
  assign rd_take = rd_rise && (!rcv_valid_q || rcv_ready);
  assign rd_drop = rd_rise && rcv_valid_q && !rcv_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_read_q   <= 1'b0;
      rcv_valid_q <= 1'b0;
      rcv_btype_q <= '0;
      fd_read_q   <= 1'b0;
    end else begin
      fs_read_q <= fs_read;
      fd_read_q <= rd_take;
      if (rd_take) begin
        rcv_valid_q <= 1'b1;
        rcv_btype_q <= read_btype;
      end else if (rcv_valid_q && rcv_ready) begin
        rcv_valid_q <= 1'b0;
      end
    end
  end

  assign fd_read   = fd_read_q;
  assign rcv_valid = rcv_valid_q;
  assign rcv_btype = rcv_btype_q;

`ifdef COM_SCHED_STAT_EN
  logic [15:0] stat_ok_q, stat_fail_q, stat_drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ok_q   <= '0;
      stat_fail_q <= '0;
      stat_drop_q <= '0;
    end else begin
      if (state_q == S_DONE && !txer_q && stat_ok_q != 16'hFFFF)   stat_ok_q   <= stat_ok_q + 16'd1;
      if (state_q == S_DONE && txer_q && stat_fail_q != 16'hFFFF)  stat_fail_q <= stat_fail_q + 16'd1;
      if (rd_drop && stat_drop_q != 16'hFFFF)                      stat_drop_q <= stat_drop_q + 16'd1;
    end
  end

  assign stat_ok   = stat_ok_q;
  assign stat_fail = stat_fail_q;
  assign stat_drop = stat_drop_q;
`else
  logic unused_drop;
  assign unused_drop = rd_drop;
`endif

endmodule

// File: tb/tb_com_sched.sv
// Directed bench for com_sched: send, round-robin, retry, fail, receive and reset-abort.
module tb_com_sched;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_send;
  logic [4*NREQ-1:0] req_btype;
  logic [12*NREQ-1:0] req_dlen;
  logic [12*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   grant, req_done, req_fail;
  logic              fs_send, fd_send, fd_txer;
  logic [3:0]        send_btype;
  logic [11:0]       send_dlen, ram_addr_init;
  logic              fs_read, fd_read, rcv_valid, rcv_ready, busy;
  logic [3:0]        read_btype, rcv_btype;
`ifdef COM_SCHED_STAT_EN
  logic [15:0]       stat_ok, stat_fail, stat_drop;
`endif

  int total = 0;
  int bad   = 0;

  com_sched #(.NREQ(NREQ), .RETRY_MAX(2)) dut (
    .clk(clk), .rst(rst), .req_send(req_send), .req_btype(req_btype),
    .req_dlen(req_dlen), .req_addr(req_addr), .grant(grant), .req_done(req_done),
    .req_fail(req_fail), .fs_send(fs_send), .fd_send(fd_send), .fd_txer(fd_txer),
    .send_btype(send_btype), .send_dlen(send_dlen), .ram_addr_init(ram_addr_init),
    .fs_read(fs_read), .read_btype(read_btype), .fd_read(fd_read),
    .rcv_valid(rcv_valid), .rcv_btype(rcv_btype), .rcv_ready(rcv_ready), .busy(busy)
`ifdef COM_SCHED_STAT_EN
    , .stat_ok(stat_ok), .stat_fail(stat_fail), .stat_drop(stat_drop)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Serves one granted transaction; fd_txer=1 on the first nfail attempts.
  task automatic send_txn(input string tag, input logic [3:0] exp_grant, input int nfail,
                          input int exp_attempts, input logic exp_fail);
    int  attempts = 0;
    int  cyc      = 0;
    bit  done     = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (req_done != '0) begin
        chk({tag, "_done"}, 32'(req_done), 32'(exp_grant));
        chk({tag, "_fail"}, 32'(req_fail), exp_fail ? 32'(exp_grant) : 32'd0);
        done = 1;
      end else if (fs_send) begin
        if (attempts == 0) chk({tag, "_grant"}, 32'(grant), 32'(exp_grant));
        attempts++;
        fd_send = 1'b1;
        fd_txer = (attempts <= nfail);
        @(negedge clk);
        cyc++;
        fd_send = 1'b0;
        fd_txer = 1'b0;
      end
    end
    chk({tag, "_finished"}, 32'(done), 32'd1);
    chk({tag, "_attempts"}, 32'(attempts), 32'(exp_attempts));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_send = '0; fd_send = 1'b0; fd_txer = 1'b0;
    fs_read = 1'b0; read_btype = '0; rcv_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_btype[4*i +: 4]  = 4'(i + 4);
      req_dlen[12*i +: 12] = 12'(16 * (i + 1));
      req_addr[12*i +: 12] = 12'(256 * i);
    end
    req_btype[7:4]  = 4'b0101;
    req_dlen[23:12] = 12'h040;
    req_addr[23:12] = 12'h100;

    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_fs_send", 32'(fs_send), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rcv_valid", 32'(rcv_valid), 32'd0);
    chk("rst_fd_read", 32'(fd_read), 32'd0);
    rst = 1'b0;

    // Single send from requester 1, fs_send exactly two cycles after the request.
    req_send = 4'b0010;
    @(negedge clk);
    chk("single_fs_send_n1", 32'(fs_send), 32'd0);
    @(negedge clk);
    chk("single_fs_send_n2", 32'(fs_send), 32'd1);
    chk("single_grant", 32'(grant), 32'b0010);
    chk("single_btype", 32'(send_btype), 32'b0101);
    chk("single_dlen", 32'(send_dlen), 32'h040);
    chk("single_addr", 32'(ram_addr_init), 32'h100);
    send_txn("single", 4'b0010, 0, 1, 1'b0);
    req_send = '0;
    @(negedge clk);
    chk("single_idle_grant", 32'(grant), 32'd0);

    // Pointer now at 2: requesters 0 and 2 pending, 2 must win.
    req_send = 4'b0101;
    send_txn("ptr2", 4'b0100, 0, 1, 1'b0);
    req_send = '0;
    @(negedge clk);

    // Round-robin from a fresh pointer.
    do_reset();
    req_send = 4'b1111;
    send_txn("rr0", 4'b0001, 0, 1, 1'b0);
    send_txn("rr1", 4'b0010, 0, 1, 1'b0);
    send_txn("rr2", 4'b0100, 0, 1, 1'b0);
    send_txn("rr3", 4'b1000, 0, 1, 1'b0);
    send_txn("rr4", 4'b0001, 0, 1, 1'b0);
    req_send = '0;
    @(negedge clk);

    // Retry then success, and exhausting all retries.
    do_reset();
    req_send = 4'b0001;
    send_txn("retry_ok", 4'b0001, 1, 2, 1'b0);
    req_send = '0;
    @(negedge clk);
    req_send = 4'b0100;
    send_txn("retry_fail", 4'b0100, 3, 3, 1'b1);
    req_send = '0;
    @(negedge clk);
`ifdef COM_SCHED_STAT_EN
    chk("stat_ok", 32'(stat_ok), 32'd1);
    chk("stat_fail", 32'(stat_fail), 32'd1);
`endif

    // Receive: capture into an empty buffer, then drop while full.
    read_btype = 4'b0001; fs_read = 1'b1;
    @(negedge clk);
    chk("rx_fd_read", 32'(fd_read), 32'd1);
    chk("rx_valid", 32'(rcv_valid), 32'd1);
    chk("rx_btype", 32'(rcv_btype), 32'b0001);
    @(negedge clk);
    chk("rx_fd_read_pulse", 32'(fd_read), 32'd0);
    fs_read = 1'b0;
    @(negedge clk);
    read_btype = 4'b0111; fs_read = 1'b1;
    @(negedge clk);
    chk("rx_drop_fd_read", 32'(fd_read), 32'd0);
    chk("rx_drop_btype", 32'(rcv_btype), 32'b0001);
`ifdef COM_SCHED_STAT_EN
    chk("stat_drop", 32'(stat_drop), 32'd1);
`endif
    fs_read = 1'b0; rcv_ready = 1'b1;
    @(negedge clk);
    chk("rx_cleared", 32'(rcv_valid), 32'd0);
    rcv_ready = 1'b0;

    // Reset while in S_SEND abandons the transaction and resets the pointer.
    do_reset();
    req_send = 4'b0100;
    repeat (2) @(negedge clk);
    chk("abort_in_send", 32'(fs_send), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_fs_send", 32'(fs_send), 32'd0);
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_done", 32'(req_done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    req_send = 4'b1111;
    send_txn("abort_ptr0", 4'b0001, 0, 1, 1'b0);
    req_send = '0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/com_sched.md
Name: com_sched

Overview:
- Round-robin scheduler that shares one com_cs link controller between NREQ packet requesters (data, param, link, temp sources).
- Send path: grants one requester, presents its btype/length/RAM address to com_cs, and runs the fs_send/fd_send handshake.
- Send path retries on fd_txer and returns done/fail to the requester.
- Receive path: acknowledges com_cs fs_read and buffers the received btype for downstream consumers. It runs independently of the send path.

Parameters:
NREQ, 4, number of requesters (legal 2..8)
RETRY_MAX, 2, extra send attempts after an fd_txer failure before fail is reported

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
req_send  in  NREQ  per-requester level request; held until its req_done pulse
req_btype  in  4*NREQ  packed btype, slice i = [4i+3:4i]
req_dlen  in  12*NREQ  packed length, slice i = [12i+11:12i]
req_addr  in  12*NREQ  packed RAM start address
grant  out  NREQ  one-hot current owner, 0 when idle
req_done  out  NREQ  1-cycle completion pulse to owner
req_fail  out  NREQ  1-cycle pulse coincident with req_done when the send failed
fs_send  out  1  start request to com_cs
fd_send  in  1  com_cs send finished (level)
fd_txer  in  1  com_cs send failed; valid only while fd_send=1
send_btype  out  4  to com_cs
send_dlen  out  12  to com_cs
ram_addr_init  out  12  to com_cs
fs_read  in  1  com_cs received packet ready (level)
read_btype  in  4  received btype from com_cs
fd_read  out  1  1-cycle acknowledge to com_cs
rcv_valid  out  1  buffered packet available
rcv_btype  out  4  buffered btype
rcv_ready  in  1  consumer accept
busy  out  1  send FSM not in S_IDLE

Behaviour:
- Reset: all outputs 0. RR pointer = 0, retry_cnt = 0, rx buffer empty. Reset mid-operation abandons the transaction with no done/fail pulse; fs_send drops the next cycle.
- Send FSM states: S_IDLE, S_ARB, S_SEND, S_DRAIN, S_RETRY, S_DONE.
- S_IDLE: any req_send bit set -> S_ARB.
- S_ARB (1 cycle):
  - Search req_send from index ptr upward, wrapping modulo NREQ; the first set bit wins.
  - Register grant, send_btype, send_dlen, ram_addr_init from the winner's slices; clear retry_cnt; -> S_SEND.
  - If no bit is set (request withdrawn), -> S_IDLE.
- Payload is latched only in S_ARB. Requester changes after grant are ignored.
- S_SEND: fs_send=1.
  - On fd_send=1, latch txer=fd_txer and -> S_DRAIN.
  - No timeout; com_cs bounds this with its own retry limit.
- S_DRAIN: fs_send=0; wait for fd_send=0.
  - txer=1 and retry_cnt<RETRY_MAX -> S_RETRY.
  - Otherwise -> S_DONE.
- S_RETRY (1 cycle): retry_cnt+1 -> S_SEND; payload unchanged.
- S_DONE (1 cycle):
  - req_done[owner]=1; req_fail[owner]=txer.
  - grant cleared; ptr = owner+1 mod NREQ; -> S_IDLE.
- Latency:
  - req in S_IDLE at cycle n -> S_ARB n+1 -> grant/payload valid and fs_send=1 at n+2.
  - After fd_send falls -> req_done 1 cycle later (success path).
- A requester whose req_send is still high after req_done is eligible again, but only after the other requesters in RR order.
- Receive path, independent of the send FSM and allowed concurrently:
  - fs_read rising edge (registered previous value) with buffer empty: capture read_btype into rcv_btype, set rcv_valid, fd_read=1 for exactly 1 cycle.
  - fs_read rising with buffer full: no fd_read; com_cs times out by itself; the packet is dropped.
  - rcv_valid&rcv_ready clears the buffer.
  - Simultaneous clear and new capture: capture wins, rcv_valid stays 1.

Optional Feature:
COM_SCHED_STAT_EN:
- Defined: adds outputs stat_ok[15:0], stat_fail[15:0], stat_drop[15:0].
  - stat_ok increments on each S_DONE with txer=0; stat_fail on each S_DONE with txer=1; stat_drop on each dropped receive.
  - Counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single send: req_send=4'b0010, btype 4'b0101, dlen 12'h040, addr 12'h100 -> grant=0010 and fs_send=1 at cycle+2 with matching outputs. Then fd_send pulse with fd_txer=0 -> req_done=0010, req_fail=0, ptr=2.
- Round-robin: req_send=4'b1111 held, each send acked -> grant order 0001,0010,0100,1000,0001.
- Retry success: fd_send with fd_txer=1 once, then fd_txer=0 -> fs_send reasserted once, req_done without req_fail, total two fs_send assertions.
- Fail: fd_txer=1 on every attempt with RETRY_MAX=2 -> three fs_send assertions, then req_done and req_fail together.
- Receive: fs_read rises with read_btype=4'b0001 and buffer empty -> fd_read 1 cycle, rcv_btype=0001. Second fs_read with rcv_ready=0 -> no fd_read, rcv_btype unchanged, stat_drop=1 (STAT_EN).
- Reset while in S_SEND -> next cycle fs_send=0, grant=0, no req_done, ptr=0.
